// File: rtl/amiq_i2c_slave.sv
// rtl/amiq_i2c_slave.sv - I2C register slave (7-bit address, 16x8 register file, pointer auto-increment).
// Define AMIQ_I2C_SLAVE_CLK_STRETCH_EN to hold SCL low for STRETCH_CYCLES after every ACK/NACK bit.
module amiq_i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h50,
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_o_en,
  output logic       sda_o_en,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK
  } state_e;

  state_e     state_q, state_d;
  logic       scl_meta_q, scl_q, scl_prev_q;
  logic       sda_meta_q, sda_q, sda_prev_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] ptr_q, ptr_d;
  logic       first_q, first_d;
  logic       nack_q, nack_d;
  logic       busy_q, busy_d;
  logic       wr_en;
  logic       wr_valid_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regfile_q [16];

  logic scl_rise, scl_fall, start_det, stop_det;

  if (STRETCH_CYCLES == 0 || STRETCH_CYCLES > 255) begin : g_bad_stretch
    $error("STRETCH_CYCLES must be in 1..255");
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_q      <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_q      <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_q      <= scl_meta_q;
      scl_prev_q <= scl_q;
      sda_meta_q <= sda_i;
      sda_q      <= sda_meta_q;
      sda_prev_q <= sda_q;
    end
  end

  assign scl_rise  = scl_q & ~scl_prev_q;
  assign scl_fall  = ~scl_q & scl_prev_q;
  assign start_det = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
  assign stop_det  = scl_q & scl_prev_q & ~sda_prev_q & sda_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      ptr_q     <= 4'd0;
      first_q   <= 1'b0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      first_q   <= first_d;
      nack_q    <= nack_d;
      busy_q    <= busy_d;
    end
  end

  // Bit 8 is counted on its rising edge; the byte is acted on at the falling edge that ends it.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    nack_d    = nack_q;
    busy_d    = busy_q;
    wr_en     = 1'b0;
    if (stop_det) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d = (shift_q[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_IDLE;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = S_RD_BYTE;
              shift_d = regfile_q[ptr_q];
            end else begin
              state_d = S_WR_BYTE;
              first_d = 1'b1;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d = S_WR_ACK;
            if (first_q) begin
              ptr_d   = shift_q[3:0];
              first_d = 1'b0;
            end else begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 4'd1;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_d   = S_WR_BYTE;
            bit_cnt_d = 4'd0;
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = S_RD_ACK;
              ptr_d   = ptr_q + 4'd1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_q;
          end else if (scl_fall) begin
            if (!nack_q) begin
              state_d   = S_RD_BYTE;
              shift_d   = regfile_q[ptr_q];
              bit_cnt_d = 4'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_o_en = 1'b0;
    case (state_q)
      S_ADDR_ACK, S_WR_ACK: sda_o_en = 1'b1;
      S_RD_BYTE:            sda_o_en = ~shift_q[7];
      default:              sda_o_en = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        regfile_q[i] <= 8'd0;
      end
    end else begin
      wr_valid_q <= wr_en;
      if (wr_en) begin
        wr_addr_q        <= ptr_q;
        wr_data_q        <= shift_q;
        regfile_q[ptr_q] <= shift_q;
      end
    end
  end

`ifdef AMIQ_I2C_SLAVE_CLK_STRETCH_EN
  localparam logic [7:0] STRETCH_LOAD = 8'(STRETCH_CYCLES);
  logic [7:0] stretch_q;
  logic       ack_end;

  assign ack_end = scl_fall && !stop_det && !start_det &&
                   (state_q inside {S_ADDR_ACK, S_WR_ACK, S_RD_ACK});

  always_ff @(posedge clock) begin
    if (reset) begin
      stretch_q <= 8'd0;
    end else if (ack_end) begin
      stretch_q <= STRETCH_LOAD;
    end else if (stretch_q != 8'd0) begin
      stretch_q <= stretch_q - 8'd1;
    end
  end

  assign scl_o_en = (stretch_q != 8'd0);
`else
  assign scl_o_en = 1'b0;
`endif

  assign scl_o    = 1'b0;
  assign sda_o    = 1'b0;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_amiq_i2c_slave.sv
// tb/tb_amiq_i2c_slave.sv - Self-checking bench for amiq_i2c_slave with an I2C master and register model.
module tb_amiq_i2c_slave;

  localparam int Q = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       bus_scl, bus_sda;
  logic       scl_o, sda_o, scl_o_en, sda_o_en, wr_valid, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign bus_scl = scl_m & ~scl_o_en;
  assign bus_sda = sda_m & ~sda_o_en;

  always #5 clock = ~clock;

  amiq_i2c_slave #(.SLAVE_ADDR(7'h50), .STRETCH_CYCLES(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .scl_i    (bus_scl),
    .sda_i    (bus_sda),
    .scl_o    (scl_o),
    .sda_o    (sda_o),
    .scl_o_en (scl_o_en),
    .sda_o_en (sda_o_en),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model_reg [16];
  logic [3:0] model_ptr;

  // Bus monitor: captured writes, SDA drive cycles, SCL stretch runs, tie-off sanity.
  logic [3:0] got_a [256];
  logic [7:0] got_d [256];
  int         wr_cnt = 0;
  int         sda_en_cycles = 0;
  int         stretch_run = 0;
  int         stretch_runs = 0;
  int         stretch_bad = 0;
  int         wr_double = 0;
  int         tie_bad = 0;
  logic       wr_prev = 1'b0;

  always @(negedge clock) begin
    if (sda_o_en) sda_en_cycles++;
    if (wr_valid && wr_cnt < 256) begin
      got_a[wr_cnt] = wr_addr;
      got_d[wr_cnt] = wr_data;
      wr_cnt++;
    end
    if (wr_valid && wr_prev) wr_double++;
    wr_prev = wr_valid;
    if (scl_o !== 1'b0 || sda_o !== 1'b0) tie_bad++;
    if (scl_o_en) begin
      stretch_run++;
    end else if (stretch_run != 0) begin
      stretch_runs++;
      if (stretch_run != 8) stretch_bad++;
      stretch_run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (bus_scl !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) chk("scl_release_timeout", 32'(bus_scl), 32'd1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q / 2);
    s = bus_sda; wait_clk(Q - Q / 2);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      b[i] = s;
    end
    bit_xfer(~master_ack, s);
  endtask

  task automatic do_write(input logic [7:0] dev, input logic [7:0] bytes[$],
                          input logic exp_ack, input int exp_writes);
    int   base, en0;
    logic ack;
    base = wr_cnt;
    en0  = sda_en_cycles;
    i2c_start();
    wr_byte(dev, ack);
    chk("addr_ack", 32'(ack), 32'(exp_ack));
    chk("busy_in_transfer", 32'(busy), 32'd1);
    foreach (bytes[i]) begin
      wr_byte(bytes[i], ack);
      chk("data_ack", 32'(ack), 32'(exp_ack));
    end
    i2c_stop();
    wait_clk(4);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("wr_pulse_count", 32'(wr_cnt - base), 32'(exp_writes));
    if (exp_ack) begin
      model_ptr = bytes[0][3:0];
      for (int i = 1; i < bytes.size(); i++) begin
        chk("wr_addr", 32'(got_a[base + i - 1]), 32'(model_ptr));
        chk("wr_data", 32'(got_d[base + i - 1]), 32'(bytes[i]));
        model_reg[model_ptr] = bytes[i];
        model_ptr = model_ptr + 4'd1;
      end
    end else begin
      chk("nack_sda_never_driven", 32'(sda_en_cycles - en0), 32'd0);
    end
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    wr_byte(8'hA0, ack);
    chk("rd_addr_w_ack", 32'(ack), 32'd1);
    wr_byte(ptr, ack);
    chk("rd_ptr_ack", 32'(ack), 32'd1);
    i2c_rstart();
    wr_byte(8'hA1, ack);
    chk("rd_addr_r_ack", 32'(ack), 32'd1);
    model_ptr = ptr[3:0];
    for (int i = 0; i < n; i++) begin
      rd_byte(i != n - 1, b);
      chk("rd_data", 32'(b), 32'(model_reg[model_ptr]));
      model_ptr = model_ptr + 4'd1;
    end
    wait_clk(2);
    chk("sda_released_after_nack", 32'(sda_o_en), 32'd0);
    chk("busy_held_until_stop", 32'(busy), 32'd1);
    i2c_stop();
    wait_clk(4);
    chk("busy_after_read_stop", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    int         exp_writes;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] bq [$];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA0, 8'h03, 8'h5A, 1'b1, 1};
    vecs[1] = '{8'hA2, 8'h00, 8'h77, 1'b0, 0};
    vecs[2] = '{8'h20, 8'h04, 8'h33, 1'b0, 0};
    vecs[3] = '{8'hA0, 8'h07, 8'hC3, 1'b1, 1};
    vecs[4] = '{8'hFE, 8'h02, 8'h99, 1'b0, 0};
    for (int i = 0; i < 16; i++) model_reg[i] = 8'h00;
    model_ptr = 4'd0;

    reset = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    chk("rst_sda_o_en", 32'(sda_o_en), 32'd0);
    chk("rst_scl_o_en", 32'(scl_o_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    for (int i = 0; i < 5; i++) begin
      bq.delete();
      bq.push_back(vecs[i].ptr);
      bq.push_back(vecs[i].data);
      do_write(vecs[i].dev, bq, vecs[i].exp_ack, vecs[i].exp_writes);
    end

    do_read(8'h03, 1);

    // Pointer wraps from 0xF to 0x0 within one burst.
    bq.delete();
    bq.push_back(8'h0F); bq.push_back(8'h11); bq.push_back(8'h22);
    do_write(8'hA0, bq, 1'b1, 2);
    do_read(8'h0F, 2);

    // Reset while the slave is presenting a 0 bit of a read byte.
    bq.delete();
    bq.push_back(8'h05); bq.push_back(8'h3C);
    do_write(8'hA0, bq, 1'b1, 1);
    begin
      logic ack;
      i2c_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h05, ack);
      i2c_rstart();
      wr_byte(8'hA1, ack);
      chk("pre_reset_ack", 32'(ack), 32'd1);
      wait_clk(8);
      chk("rd_bit7_driven", 32'(sda_o_en), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_reset_sda_o_en", 32'(sda_o_en), 32'd0);
      chk("mid_reset_busy", 32'(busy), 32'd0);
      chk("mid_reset_scl_o_en", 32'(scl_o_en), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) model_reg[i] = 8'h00;
      model_ptr = 4'd0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      wait_clk(2 * Q);
    end
    do_read(8'h05, 1);

    for (int t = 0; t < 6; t++) begin
      logic [7:0] p;
      int         n;
      p = 8'($urandom_range(0, 15));
      n = $urandom_range(1, 3);
      bq.delete();
      bq.push_back(p);
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom_range(0, 255)));
      do_write(8'hA0, bq, 1'b1, n);
      do_read(p, n + 1);
    end

    wait_clk(4);
    chk("wr_valid_single_cycle", 32'(wr_double), 32'd0);
    chk("open_drain_levels_low", 32'(tie_bad), 32'd0);
`ifdef AMIQ_I2C_SLAVE_CLK_STRETCH_EN
    chk("stretch_run_length", 32'(stretch_bad), 32'd0);
    chk("stretch_seen", 32'(stretch_runs != 0), 32'd1);
`else
    chk("scl_o_en_never", 32'(stretch_runs + stretch_run), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
